// File: rtl/pool_seq.sv
// 2x2 stride-2 max-pool sequencer: streams window reads from BRAM and writes one unsigned maximum per window.
// Latency: first read one cycle after start, each result two cycles after its window's last read, done 4*N+3 cycles after start.
// Backpressure: none, one read per cycle with no bubbles; start is ignored unless idle.
module pool_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_DIM    = 16,
    localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIM_W-1:0]      cfg_width,
    input  logic [DIM_W-1:0]      cfg_height,
    input  logic [ADDR_WIDTH-1:0] cfg_src_base,
    input  logic [ADDR_WIDTH-1:0] cfg_dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t state_q, state_n;

    logic [DIM_W-1:0]      w_q, h_q, col_q, row_q, col_n, row_n;
    logic [1:0]            slot_q, slot_n, slot_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_n, dst_q, next_addr;
    logic                  rd_vld_d, drain_q;
    logic                  cfg_ok, col_last, row_last, last_rd;
    logic [DATA_WIDTH-1:0] max_q, win_max;

    assign cfg_ok = !cfg_width[0] && !cfg_height[0]
                 && (cfg_width  >= DIM_W'(2)) && (cfg_width  <= DIM_W'(MAX_DIM))
                 && (cfg_height >= DIM_W'(2)) && (cfg_height <= DIM_W'(MAX_DIM));

    assign col_last = (col_q == w_q - DIM_W'(2));
    assign row_last = (row_q == h_q - DIM_W'(2));
    assign last_rd  = (slot_q == 2'd3) && col_last && row_last;

    // rp tracks src_base + r*W so every address is a pair of adds, never a multiply
    always_comb begin
        slot_n = slot_q + 2'd1;
        col_n  = col_q;
        row_n  = row_q;
        rp_n   = rp_q;
        if (slot_q == 2'd3) begin
            if (col_last) begin
                col_n = '0;
                row_n = row_q + DIM_W'(2);
                rp_n  = rp_q + ADDR_WIDTH'({w_q, 1'b0});
            end else begin
                col_n = col_q + DIM_W'(2);
            end
        end
        next_addr = rp_n + (slot_n[1] ? ADDR_WIDTH'(w_q) : '0)
                  + ADDR_WIDTH'(col_n) + ADDR_WIDTH'(slot_n[0]);
    end

    // slot 0 opens a fresh window; later slots keep the held value on ties
    assign win_max = ((slot_d == 2'd0) || (rd_data > max_q)) ? rd_data : max_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_n = cfg_ok ? S_READ : S_ERR;
            S_READ: begin
                busy = 1'b1;
                if (last_rd) state_n = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (drain_q) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            S_ERR: begin
                err     = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            slot_q   <= '0;
            slot_d   <= '0;
            rp_q     <= '0;
            dst_q    <= '0;
            rd_vld_d <= 1'b0;
            drain_q  <= 1'b0;
            max_q    <= '0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_en    <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            rd_vld_d <= 1'b0;
            drain_q  <= (state_q == S_DRAIN) && !drain_q;

            if (state_q == S_IDLE && start && cfg_ok) begin
                w_q     <= cfg_width;
                h_q     <= cfg_height;
                rp_q    <= cfg_src_base;
                dst_q   <= cfg_dst_base;
                rd_addr <= cfg_src_base;
                slot_q  <= '0;
                col_q   <= '0;
                row_q   <= '0;
            end

            if (state_q == S_READ) begin
                rd_vld_d <= 1'b1;
                slot_d   <= slot_q;
                if (!last_rd) begin
                    slot_q  <= slot_n;
                    col_q   <= col_n;
                    row_q   <= row_n;
                    rp_q    <= rp_n;
                    rd_addr <= next_addr;
                end
            end

            if (rd_vld_d) begin
                max_q <= win_max;
                if (slot_d == 2'd3) begin
                    wr_en   <= 1'b1;
                    wr_data <= win_max;
                    wr_addr <= dst_q;
                    dst_q   <= dst_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_pool_seq.sv
// Bench for pool_seq: BRAM model, window-level reference model, cycle-by-cycle checks of every job.
module tb_pool_seq;

    localparam int DIM_W = 5;

    logic             clk = 1'b0;
    logic             rst, start;
    logic [DIM_W-1:0] cfg_width, cfg_height;
    logic [7:0]       cfg_src_base, cfg_dst_base;
    logic             busy, done, err, wr_en;
    logic [7:0]       rd_addr, rd_data, wr_addr, wr_data;

    logic             ld_en;
    logic [7:0]       ld_addr, ld_dat;
    logic [7:0]       mem     [256];
    logic [7:0]       ref_mem [256];

    logic [7:0]       e_rd [$];
    logic [7:0]       e_wa [$];
    logic [7:0]       e_wd [$];
    logic [7:0]       exp_rd_hold;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pool_seq dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_width    (cfg_width),
        .cfg_height   (cfg_height),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en)
    );

    always @(posedge clk) begin
        rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
        if (ld_en) mem[ld_addr] <= ld_dat;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] v);
        ld_addr    = a;
        ld_dat     = v;
        ld_en      = 1'b1;
        ref_mem[a] = v;
        step();
        ld_en      = 1'b0;
    endtask

    // Window-order read list and one max per window, straight from the geometry
    task automatic build_model(input int w, input int h, input logic [7:0] src, input logic [7:0] dst);
        logic [7:0] a [4];
        logic [7:0] m;
        int k;
        e_rd.delete();
        e_wa.delete();
        e_wd.delete();
        k = 0;
        for (int r = 0; r < h; r += 2) begin
            for (int c = 0; c < w; c += 2) begin
                a[0] = src + 8'(r * w + c);
                a[1] = src + 8'(r * w + c + 1);
                a[2] = src + 8'((r + 1) * w + c);
                a[3] = src + 8'((r + 1) * w + c + 1);
                m = 8'd0;
                for (int s = 0; s < 4; s++) begin
                    e_rd.push_back(a[s]);
                    if (ref_mem[a[s]] > m) m = ref_mem[a[s]];
                end
                e_wa.push_back(dst + 8'(k));
                e_wd.push_back(m);
                k++;
            end
        end
    endtask

    // Returns sampled in the done cycle (or in cycle stop_at when nonzero)
    task automatic run_job(input int w, input int h, input logic [7:0] src, input logic [7:0] dst,
                           input bit disturb, input int stop_at);
        int nw, t_done, last, j;
        bit we_exp;
        build_model(w, h, src, dst);
        nw     = (w / 2) * (h / 2);
        t_done = 4 * nw + 3;
        last   = (stop_at != 0) ? stop_at : t_done;
        cfg_width    = DIM_W'(w);
        cfg_height   = DIM_W'(h);
        cfg_src_base = src;
        cfg_dst_base = dst;
        start        = 1'b1;
        step();
        start        = 1'b0;
        for (int n = 1; n <= last; n++) begin
            chk("busy", busy, n <= t_done - 1);
            chk("done", done, n == t_done);
            chk("err", err, 1'b0);
            we_exp = (n >= 6) && (n <= t_done - 1) && ((n - 6) % 4 == 0);
            chk("wr_en", wr_en, we_exp);
            if (we_exp) begin
                j = (n - 6) / 4;
                chk("wr_addr", wr_addr, e_wa[j]);
                chk("wr_data", wr_data, e_wd[j]);
            end
            chk("rd_addr", rd_addr, (n <= 4 * nw) ? e_rd[n - 1] : e_rd[4 * nw - 1]);
            if (disturb && (n % 3 == 0) && n < t_done) begin
                start        = 1'b1;
                cfg_width    = DIM_W'($urandom);
                cfg_height   = DIM_W'($urandom);
                cfg_src_base = 8'($urandom);
                cfg_dst_base = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            if (n < last) step();
        end
        start = 1'b0;
        if (stop_at == 0) begin
            for (int i = 0; i < nw; i++) ref_mem[e_wa[i]] = e_wd[i];
            exp_rd_hold = e_rd[4 * nw - 1];
        end
    endtask

    task automatic run_err(input int w, input int h);
        cfg_width    = DIM_W'(w);
        cfg_height   = DIM_W'(h);
        cfg_src_base = 8'hA0;
        cfg_dst_base = 8'hB0;
        start        = 1'b1;
        step();
        start        = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            chk("cfg_err", err, n == 1);
            chk("cfg_busy", busy, 1'b0);
            chk("cfg_done", done, 1'b0);
            chk("cfg_wr_en", wr_en, 1'b0);
            chk("cfg_rd_addr", rd_addr, exp_rd_hold);
            step();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_wr_en"}, wr_en, 1'b0);
        chk({tag, "_rd_addr"}, rd_addr, 8'h00);
        chk({tag, "_wr_addr"}, wr_addr, 8'h00);
        chk({tag, "_wr_data"}, wr_data, 8'h00);
    endtask

    initial begin
        int w, h;
        logic [7:0] src;
        rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_dat = '0;
        cfg_width = '0; cfg_height = '0; cfg_src_base = '0; cfg_dst_base = '0;
        exp_rd_hold = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        step();
        step();
        chk_reset_vals("rst");
        rst = 1'b0;
        step();

        // 4x4 ramp: results 5,7,13,15 at 16..19
        for (int i = 0; i < 16; i++) load(8'(i), 8'(i));
        run_job(4, 4, 8'h00, 8'h10, 1'b0, 0);
        chk("ramp_w3", e_wd[3], 8'd15);
        step();

        // 2x2 with a tie on the maximum
        load(8'h40, 8'd9); load(8'h41, 8'd200); load(8'h42, 8'd200); load(8'h43, 8'd3);
        run_job(2, 2, 8'h40, 8'h80, 1'b0, 0);
        step();

        run_err(3, 4);
        run_err(4, 0);
        run_err(18, 4);

        // source and destination address wrap
        load(8'hFE, 8'd11); load(8'hFF, 8'd77); load(8'h00, 8'd66); load(8'h01, 8'd12);
        run_job(2, 2, 8'hFE, 8'h10, 1'b0, 0);
        step();
        for (int i = 0; i < 8; i++) load(8'(8'h20 + i), 8'($urandom));
        run_job(4, 2, 8'h20, 8'hFF, 1'b0, 0);
        step();

        // disturbed job, start in done cycle ignored, start the cycle after accepted
        for (int i = 0; i < 8; i++) load(8'(8'h60 + i), 8'($urandom));
        run_job(4, 4, 8'h00, 8'h50, 1'b1, 0);
        start = 1'b1;
        cfg_width = DIM_W'(2); cfg_height = DIM_W'(2);
        step();
        start = 1'b0;
        chk("done_start_busy", busy, 1'b0);
        chk("done_start_rd_addr", rd_addr, exp_rd_hold);
        run_job(2, 4, 8'h60, 8'h70, 1'b0, 0);
        step();

        // reset in cycle 8 of a 4x4 job, then a clean rerun
        run_job(4, 4, 8'h00, 8'h30, 1'b0, 8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ref_mem[e_wa[0]] = e_wd[0];
        exp_rd_hold = 8'h00;
        chk_reset_vals("abort");
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_wr_en", wr_en, 1'b0);
            chk("abort_busy", busy, 1'b0);
        end
        run_job(4, 4, 8'h00, 8'h30, 1'b0, 0);
        step();

        // random geometry and contents, destination placed just past the source
        for (int t = 0; t < 4; t++) begin
            w = 2 * $urandom_range(1, 4);
            h = 2 * $urandom_range(1, 4);
            src = 8'($urandom);
            for (int i = 0; i < w * h; i++) load(8'(src + 8'(i)), 8'($urandom));
            run_job(w, h, src, 8'(src + 8'(w * h)), 1'b0, 0);
            step();
        end

        // largest legal width, then largest legal height
        for (int i = 0; i < 32; i++) load(8'(8'h90 + i), 8'($urandom));
        run_job(16, 2, 8'h90, 8'hC0, 1'b0, 0);
        step();
        run_job(2, 16, 8'h90, 8'hD0, 1'b0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pool_seq.md
Name: pool_seq

Overview:
Sequencer for 2x2, stride-2 max pooling over a feature map held in a single-port-read / single-port-write synchronous BRAM (1-cycle registered read latency). On a start pulse it latches the map geometry and base addresses, streams reads in window order, reduces each window to its unsigned maximum and writes results to a destination region in output raster order. It sits between the layer controller (start/done) and the BRAM ports, replacing free-running address generation with a bounded, restartable job.

Parameters:
ADDR_WIDTH, 8, BRAM address width; all address arithmetic wraps modulo 2^ADDR_WIDTH
DATA_WIDTH, 8, pixel width, unsigned
MAX_DIM, 16, largest legal map width/height
DIM_W, $clog2(MAX_DIM)+1, width of geometry inputs (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job request, sampled only in IDLE
cfg_width  in  DIM_W  map width in pixels
cfg_height  in  DIM_W  map height in pixels
cfg_src_base  in  ADDR_WIDTH  address of pixel (0,0)
cfg_dst_base  in  ADDR_WIDTH  address of output (0,0)
busy  out  1  job in progress
done  out  1  one-cycle pulse, job complete
err  out  1  one-cycle pulse, config rejected
rd_addr  out  ADDR_WIDTH  BRAM read address
rd_data  in  DATA_WIDTH  BRAM read data, valid the cycle after rd_addr
wr_addr  out  ADDR_WIDTH  BRAM write address
wr_data  out  DATA_WIDTH  window maximum
wr_en  out  1  BRAM write strobe

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, err=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0. Reset mid-job aborts immediately: no further wr_en, in-flight reads discarded.
- FSM: IDLE -> CHECK on start (edge = cycle 0; cfg_* latched there). CHECK is folded into cycle 1: legal -> READ, illegal -> err=1 in cycle 1, back to IDLE, no rd/wr activity, busy stays 0.
- Legal config: width and height even, >=2, <=MAX_DIM.
- READ: busy=1 from cycle 1. One read per cycle, no bubbles, starting cycle 1. Per window at (r,c): order (r,c),(r,c+1),(r+1,c),(r+1,c+1). Windows visited c=0,2,..,W-2 then r+=2. Address = src_base + r*W + c, formed with a running row pointer (no multiplier), wrap modulo 2^ADDR_WIDTH.
- Reduction pipeline: a read-valid tag and slot index (0..3) delayed 1 cycle accompany rd_data. Slot 0 loads max register directly; slots 1-3 replace when rd_data > max (unsigned, ties keep held value). Result written 2 cycles after the window's last read: wr_en=1, wr_data=max, for exactly one cycle.
- wr_addr: dst_base for first window, +1 per subsequent window (wrap modulo 2^ADDR_WIDTH). Outputs = (W/2)*(H/2).
- DRAIN: after the last read, 2 cycles until last write completes; busy stays 1 through the last wr_en cycle.
- DONE: done=1 for one cycle immediately after last wr_en cycle, busy=0 that cycle; return to IDLE. New start accepted in the done cycle? No -- accepted from the cycle after done onward.
- start while busy or in done cycle: ignored, not queued. cfg_* changes after cycle 0 have no effect.
- rd_addr holds last value when not reading; wr_addr holds last written address; wr_data holds last max.
- Reads and writes may alias (dst overlapping src); block performs no hazard check, order above is the contract.
- Total job cycles (start edge to done): 4*N + 3, N = window count.

Test Plan:
- 4x4 map, src_base=0 holding 0..15, dst_base=16, start at cycle 0 -> reads cycles 1..16; wr_en cycles 6,10,14,18 writing 5,7,13,15 to addrs 16..19; done at cycle 19; busy high cycles 1..18.
- 2x2 map, values 9,200,200,3 at src 0x40, dst 0x80 -> single write 200 to 0x80 at cycle 6, done cycle 7; tie on 200 yields 200.
- cfg_width=3 (and separately height=0, width=MAX_DIM+2) -> err pulse cycle 1, no rd_addr change, wr_en never asserted, busy 0, done 0.
- src_base=0xFE, 2x2 map, dst_base=0xFF, 4x2 map -> read addresses wrap 0xFE,0xFF,0x00,0x01; second output written to 0x00.
- start re-pulsed during busy and cfg changed mid-job -> ignored, outputs identical to undisturbed run; start at cycle after done -> second job begins next cycle.
- rst asserted in cycle 8 of 4x4 job -> from cycle 9 all outputs at reset values, no wr_en; following start runs full job correctly.
